// File: rtl/flop_pair_stim_chk.sv
// Stimulus driver and response checker for the two-flop capture block.
// Define FLOP_PAIR_STIM_CHK_OP2_EN to add the op2 input and check it as well.
module flop_pair_stim_chk #(
    parameter int CHECK_LAT = 2,
    parameter int ERR_W     = 4
) (
    input  logic             clk,
    input  logic             clear0,
    input  logic             start,
`ifdef FLOP_PAIR_STIM_CHK_OP2_EN
    input  logic             op2,
`endif
    input  logic             op0,
    input  logic             op1,
    output logic             ip0,
    output logic             ip1,
    output logic             ip2,
    output logic             ip3,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // {ip3,ip2,ip1,ip0} and expected {op1,op0}, entry 7 first
    localparam logic [7:0][3:0] VEC_TBL = {4'b0000, 4'b1111, 4'b0011, 4'b1010,
                                           4'b0101, 4'b1100, 4'b0000, 4'b0011};
    localparam logic [7:0][1:0] EXP_TBL = {2'b10, 2'b01, 2'b11, 2'b00,
                                           2'b00, 2'b00, 2'b10, 2'b11};
    localparam logic [1:0]       DRAIN_LAST = 2'((CHECK_LAT > 1) ? CHECK_LAT - 2 : 0);
    localparam logic [ERR_W-1:0] ERR_MAX    = '1;
    localparam logic [ERR_W-1:0] ERR_ONE    = ERR_W'(1);

    state_t                      state, state_nxt;
    logic [2:0]                  idx, idx_nxt;
    logic [1:0]                  drain_cnt;
    logic                        drive_en, run_go, run_fin, miss;
    logic [CHECK_LAT:1]          vld_pipe;
    logic [CHECK_LAT:1][1:0]     exp_pipe;

    always_ff @(posedge clk or negedge clear0) begin
        if (!clear0) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        drive_en  = 1'b0;
        run_go    = 1'b0;
        run_fin   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    run_go    = 1'b1;
                    drive_en  = 1'b1;
                    idx_nxt   = 3'd0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (idx == 3'd7) begin
                    // with a one-edge latency the final compare lands on the exit edge
                    if (CHECK_LAT == 1) begin
                        run_fin   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end else begin
                    idx_nxt  = idx + 3'd1;
                    drive_en = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    run_fin   = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
`ifdef FLOP_PAIR_STIM_CHK_OP2_EN
        miss = ({op1, op0} != exp_pipe[CHECK_LAT]) || (op2 != ~(op0 & op1));
`else
        miss = ({op1, op0} != exp_pipe[CHECK_LAT]);
`endif
    end

    always_ff @(posedge clk or negedge clear0) begin
        if (!clear0) begin
            idx                  <= '0;
            drain_cnt            <= '0;
            {ip3, ip2, ip1, ip0} <= '0;
            vld_pipe             <= '0;
            exp_pipe             <= '0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            err_cnt              <= '0;
        end else begin
            idx                  <= idx_nxt;
            drain_cnt            <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            {ip3, ip2, ip1, ip0} <= drive_en ? VEC_TBL[idx_nxt] : 4'b0000;
            // expected value rides alongside the vector until its sample edge
            vld_pipe[1]          <= drive_en;
            exp_pipe[1]          <= EXP_TBL[idx_nxt];
            for (int i = 2; i <= CHECK_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                exp_pipe[i] <= exp_pipe[i-1];
            end
            if (run_go) begin
                busy    <= 1'b1;
                done    <= 1'b0;
                err_cnt <= '0;
            end else if (vld_pipe[CHECK_LAT] && miss && err_cnt != ERR_MAX) begin
                err_cnt <= err_cnt + ERR_ONE;
            end
            if (run_fin) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    assign pass = done & (err_cnt == '0);

endmodule

// File: tb/tb_flop_pair_stim_chk.sv
// Bench for flop_pair_stim_chk: behavioural capture block with fault injection in the loop.
module tb_flop_pair_stim_chk;
    localparam int CHECK_LAT = 2;
    localparam int ERR_W     = 4;

    logic clk = 1'b0, clear0 = 1'b1, start = 1'b0;
    logic ip0, ip1, ip2, ip3, busy, done, pass;
    logic [ERR_W-1:0] err_cnt;
    logic cap0, cap1, op0, op1;
    logic [1:0] flip = 2'b00;
    logic s0_en = 1'b0, s0_v = 1'b0, s1_en = 1'b0, s1_v = 1'b0;

    int n_chk = 0, n_pass = 0;

    logic [3:0] vec [8] = '{4'b0011, 4'b0000, 4'b1100, 4'b0101,
                            4'b1010, 4'b0011, 4'b1111, 4'b0000};

    typedef struct {
        bit    s0_en, s0_v, s1_en, s1_v;
        int    exp_err;
        string tag;
    } rec_t;
    rec_t tbl [6];

    flop_pair_stim_chk #(.CHECK_LAT(CHECK_LAT), .ERR_W(ERR_W)) dut (
        .clk(clk), .clear0(clear0), .start(start), .op0(op0), .op1(op1),
        .ip0(ip0), .ip1(ip1), .ip2(ip2), .ip3(ip3),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // capture block under test, with per-vector bit flips and stuck-at overrides
    always @(posedge clk) begin
        cap0 <= (ip0 & ip1) ^ flip[0];
        cap1 <= ~(ip2 | ip3) ^ flip[1];
    end
    assign op0 = s0_en ? s0_v : cap0;
    assign op1 = s1_en ? s1_v : cap1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // expected error count from the capture rules plus the injected faults
    function automatic int model_err(input logic [7:0][1:0] mask, input bit a0, input bit v0,
                                     input bit a1, input bit v1);
        int cnt = 0;
        for (int k = 0; k < 8; k++) begin
            logic good0, good1, got0, got1;
            good0 = vec[k][0] & vec[k][1];
            good1 = ~(vec[k][2] | vec[k][3]);
            got0  = a0 ? v0 : good0 ^ mask[k][0];
            got1  = a1 ? v1 : good1 ^ mask[k][1];
            if (got0 != good0 || got1 != good1) cnt++;
        end
        return (cnt > (1 << ERR_W) - 1) ? (1 << ERR_W) - 1 : cnt;
    endfunction

    task automatic run_chk(input logic [7:0][1:0] mask, input bit hold, input int exp_err,
                           input string tag);
        int busy_n = 0;
        @(negedge clk); start = 1'b1; flip = 2'b00;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (busy) busy_n++;
            chk({tag, " ip"}, int'({ip3, ip2, ip1, ip0}), int'(vec[n]));
            flip = mask[n];
        end
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            flip = 2'b00;
            if (busy) busy_n++;
            if (t == 0) chk({tag, " ip_idle"}, int'({ip3, ip2, ip1, ip0}), 0);
        end
        start = 1'b0;
        chk({tag, " done"}, int'(done), 1);
        chk({tag, " busy_cycles"}, busy_n, 7 + CHECK_LAT);
        chk({tag, " err_cnt"}, int'(err_cnt), exp_err);
        chk({tag, " pass"}, int'(pass), int'(exp_err == 0));
        @(negedge clk);
        chk({tag, " held"}, int'({busy, done, err_cnt}), int'({1'b0, 1'b1, ERR_W'(exp_err)}));
    endtask

    initial begin
        logic [7:0][1:0] mask;
        int e;
        tbl[0] = '{0, 0, 0, 0, 0, "ideal"};
        tbl[1] = '{0, 0, 1, 0, 4, "op1_sa0"};
        tbl[2] = '{1, 1, 0, 0, 5, "op0_sa1"};
        tbl[3] = '{1, 0, 0, 0, 3, "op0_sa0"};
        tbl[4] = '{0, 0, 1, 1, 4, "op1_sa1"};
        tbl[5] = '{1, 1, 1, 0, 7, "both_stuck"};

        #1 clear0 = 1'b0;
        #1 chk("reset_outputs", int'({ip3, ip2, ip1, ip0, busy, done, pass, err_cnt}), 0);
        @(negedge clk); clear0 = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", int'({busy, done, pass}), 0);

        // table: each run restarts from DONE, so err_cnt must clear every time
        for (int i = 0; i < 6; i++) begin
            {s0_en, s0_v, s1_en, s1_v} = {tbl[i].s0_en, tbl[i].s0_v, tbl[i].s1_en, tbl[i].s1_v};
            run_chk('0, 1'b0, tbl[i].exp_err, tbl[i].tag);
            chk({tbl[i].tag, " model"}, model_err('0, s0_en, s0_v, s1_en, s1_v), tbl[i].exp_err);
        end
        {s0_en, s1_en} = 2'b00;

        // start held high through the whole run: exactly one run
        run_chk('0, 1'b1, 0, "start_held");
        @(negedge clk);
        chk("no_rerun", int'({busy, done}), int'(2'b01));

        // async clear mid-run after some errors have accumulated
        s1_en = 1'b1; s1_v = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int n = 1; n <= 4; n++) @(negedge clk);
        chk("pre_clear_err", int'(err_cnt), 2);
        #2 clear0 = 1'b0;
        #1 chk("clear_async", int'({ip3, ip2, ip1, ip0, busy, done, pass, err_cnt}), 0);
        #24 clear0 = 1'b1;
        s1_en = 1'b0;
        @(negedge clk);
        chk("clear_idle", int'({ip3, ip2, ip1, ip0, busy, done, err_cnt}), 0);
        run_chk('0, 1'b0, 0, "post_clear");

        // random per-vector bit flips against the model
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 8; k++)
                mask[k] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            e = model_err(mask, 1'b0, 1'b0, 1'b0, 1'b0);
            run_chk(mask, 1'($urandom_range(0, 1)), e, $sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
